// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS            = 8;
  localparam logic UART_IDLE_LEVEL           = 1'b1;
  localparam int   UART_DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; bit_end marks the last clock of each serial bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_end = (count == CNT_MAX);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: start bit, LSB-first data, one stop bit; all outputs registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_tx_state_t       state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [IDX_W-1:0]     bit_idx, idx_next;
  logic                 tx_next, busy_next, done_next;
  logic                 bit_end;

  // Holding the counter clear in IDLE makes START begin at count 0.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    shift_next = shift;
    idx_next   = bit_idx;
    tx_next    = UART_IDLE_LEVEL;
    busy_next  = 1'b1;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (tx_start) begin
          state_next = START;
          shift_next = tx_data;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (bit_end) begin
          shift_next = {1'b0, shift[DATA_BITS-1:1]};
          idx_next   = bit_idx + 1'b1;
          tx_next    = shift[1];
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
            tx_next    = UART_IDLE_LEVEL;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Outputs are flopped from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= UART_IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= idx_next;
      tx      <= tx_next;
      tx_busy <= busy_next;
      tx_done <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: fast instance (4 clks/bit) plus one at the default rate.
module tb_uart_tx_serializer;

  localparam int CPB  = 4;
  localparam int SLOW = 5208;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, tx_done;

  logic       s_start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_tx, s_busy, s_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  uart_tx_serializer dut_slow (
    .clk     (clk),
    .rst     (rst),
    .tx_start(s_start),
    .tx_data (s_data),
    .tx      (s_tx),
    .tx_busy (s_busy),
    .tx_done (s_done)
  );

  // Expected line level for frame bit b: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  // Starts and ends on a negedge; ends in the tx_done cycle after checking it.
  task automatic send_frame(input logic [7:0] d, input string name,
                            input int inject_at, input logic [7:0] inject_data);
    logic exp;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
    for (int k = 1; k <= 10 * CPB; k++) begin
      exp = frame_bit(d, (k - 1) / CPB);
      tests_run++;
      if (tx !== exp || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                 name, k, tx, tx_busy, tx_done, exp);
      end
      if (k == inject_at) begin
        tx_start = 1'b1;
        tx_data  = inject_data;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tests_run++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s done cycle: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=1",
               name, tx, tx_busy, tx_done);
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s idle %0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
                 name, i, tx, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || s_tx !== 1'b1 || s_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset hold %0d: tx=%b busy=%b done=%b s_tx=%b s_busy=%b, expected 1/0/0/1/0",
                 i, tx, tx_busy, tx_done, s_tx, s_busy);
      end
    end
    rst      = 1'b0;
    tx_start = 1'b0;
    idle_cycles("reset release", 6);
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, "single_a5", 0, 8'h00);
    idle_cycles("single_a5 after", 3);
  endtask

  task automatic test_busy_ignore();
    send_frame(8'h0F, "busy_ignore", 15, 8'hFF);
    idle_cycles("busy_ignore after", 12);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, "b2b_first", 0, 8'h00);
    send_frame(8'h00, "b2b_second", 0, 8'h00);
    idle_cycles("b2b after", 3);
  endtask

  task automatic test_mid_reset();
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clk);
    tests_run++;
    if (tx !== frame_bit(8'h3C, 4) || tx_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset pre: tx=%b busy=%b, expected tx=%b busy=1",
               tx, tx_busy, frame_bit(8'h3C, 4));
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset abort: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0",
               tx, tx_busy, tx_done);
    end
    rst = 1'b0;
    idle_cycles("mid_reset after", 8);
    send_frame(8'h81, "after_reset_81", 0, 8'h00);
    idle_cycles("after_reset_81 after", 2);
  endtask

  task automatic test_default_rate();
    logic [7:0] rx;
    int busy_cnt;
    int errs;
    logic exp;
    rx       = 8'h00;
    busy_cnt = 0;
    s_data   = 8'h41;
    s_start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    s_data  = 8'h00;
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      exp  = frame_bit(8'h41, b);
      for (int c = 0; c < SLOW; c++) begin
        if (s_tx !== exp) errs++;
        if (s_busy === 1'b1) busy_cnt++;
        if (c == SLOW / 2 && b >= 1 && b <= 8) rx[b-1] = s_tx;
        @(negedge clk);
      end
      tests_run++;
      if (errs != 0) begin
        tests_failed++;
        $display("FAIL slow bit %0d: %0d of %0d cycles wrong, expected level %b throughout",
                 b, errs, SLOW, exp);
      end
    end
    tests_run++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL slow done: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=1",
               s_tx, s_busy, s_done);
    end
    tests_run++;
    if (busy_cnt != 10 * SLOW) begin
      tests_failed++;
      $display("FAIL slow busy length: got %0d cycles, expected %0d", busy_cnt, 10 * SLOW);
    end
    tests_run++;
    if (rx !== 8'h41) begin
      tests_failed++;
      $display("FAIL slow loopback: got %h, expected 41", rx);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_default_rate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- 8N1 UART transmitter: the transmit-side counterpart of the FPGA-top UART receive path.
- Accepts a parallel byte with a start strobe, then serializes it on `tx`: start bit, 8 data bits LSB first, 1 stop bit.
- Provides `busy` and `done` status for the top-level controller.
- Sits beside the receiver in the UART FPGA top. It shares the same clock and baud configuration.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥2.
- DATA_BITS, 8, payload bits per frame; fixed at 8 in this release.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- tx_start  input  1  one-cycle request to send `tx_data`; honoured only in IDLE.
- tx_data  input  8  byte to send; sampled only in the accept cycle.
- tx  output  1  serial line; idle level 1.
- tx_busy  output  1  high from the cycle after accept through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, tx=1, tx_busy=0, tx_done=0.
  - baud counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame immediately; `tx` returns to 1 on the next cycle and no `tx_done` is generated.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1, `tx_busy`=0.
  - If `tx_start`=1, latch `tx_data` into the shift register and go to START with baud counter=0.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - `tx`=shift[0] for CLKS_PER_BIT cycles.
  - At the end of each bit: shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE and assert `tx_done` for exactly that first IDLE cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The bit ends when counter==CLKS_PER_BIT-1; the counter wraps to 0 on every state transition.
  - Counter width is $clog2(CLKS_PER_BIT).
- Timing:
  - Accept edge N puts `tx` low starting at cycle N+1.
  - The frame occupies exactly 10*CLKS_PER_BIT cycles of `tx_busy`=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Handshake rules:
  - `tx_start` while `tx_busy`=1 is ignored: no queueing and no corruption of the frame in flight.
  - `tx_data` changes after accept do not affect the frame.
- Back-to-back frames:
  - `tx_start` in the same cycle `tx_done`=1 (state IDLE) is accepted.
  - The minimum gap between frames is therefore exactly 1 idle-high cycle after the stop bit.
- `tx_start` held high continuously sends frames repeatedly, separated by that 1-cycle gap.
- `tx_start` coinciding with `rst`=1: reset wins.

Decomposition:
- Package `uart_pkg`:
  - typedef enum logic [1:0] `uart_tx_state_t` {IDLE, START, DATA, STOP}.
  - Constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1'b1, `UART_DEFAULT_CLKS_PER_BIT`=5208.
- The receiver shares this package.
- One sub-module: `uart_baud_counter`.
  - Parameter CLKS_PER_BIT; inputs clk, rst, clear.
  - Output `bit_end` pulse.
  - Reusable by the receiver.

Test Plan (CLKS_PER_BIT=4 unless noted):
1. Reset: hold rst=1 for 3 cycles with tx_start=1 → tx=1, tx_busy=0, tx_done=0 throughout, and no frame starts after release.
2. Single byte 0xA5: tx_start pulse at edge N → tx stream per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1 starting cycle N+1. tx_busy=1 for exactly 40 cycles. tx_done=1 for one cycle at N+41.
3. Busy-ignore: send 0x0F, then pulse tx_start with tx_data=0xFF at cycle N+15 → line carries only the 0x0F frame and exactly one tx_done.
4. Back-to-back: 0x55, then 0x00 with tx_start asserted in the tx_done cycle → exactly one tx=1 cycle between the first stop bit and the second start bit. Second frame data bits all 0.
5. Mid-frame reset: rst=1 at cycle N+20 of a 0x3C frame → tx=1 next cycle, tx_busy=0, no tx_done. A fresh 0x81 frame afterwards is correct.
6. Default parameter CLKS_PER_BIT=5208, byte 0x41 → each bit measures 5208 cycles and the frame measures 52080 cycles. Receiver loopback returns 0x41.
